sensor_frame_buffer: RTL and testbench
======================================

# sensor_frame_buffer

Double-buffered frame assembler between the dual BNO085 controller and the MCU SPI slave. Captures one complete two-sensor sample (quaternion and gyro for each sensor) on every `data_ready` pulse into a back buffer. Serialises the front buffer as a fixed byte frame over a ready/ack byte handshake. A new sample arriving mid-frame never corrupts the frame in flight.

## Interface
- `HEADER_BYTE`, default 8'hAA: first byte of every frame.
- `clk` in 1: system clock (HSOSC-derived); all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data_ready` in 1: one-cycle pulse; sample inputs valid in the same cycle.
- `sensor1_valid`, `sensor2_valid` in 1 each: per-sensor validity, sampled with `data_ready`.
- `quat1_w/x/y/z`, `gyro1_x/y/z`, `quat2_w/x/y/z`, `gyro2_x/y/z` in 16 each, signed: sample words.
- `tx_data_ready` out 1: `tx_data` holds a valid unsent byte.
- `tx_data` out 8: current frame byte.
- `tx_ack` in 1: one-cycle pulse from the SPI slave; consumes the current byte.
- `busy` out 1: high while in SEND or while a frame is pending.
- `dropped_count` out 8: saturating count of overwritten pending frames.

## Operation
- **Frame layout** (byte index):
  - 0: `HEADER_BYTE`.
  - 1: flags. Bit 0 = `sensor1_valid`, bit 1 = `sensor2_valid`, bits 7:2 = sequence number mod 64.
  - 2..29: fourteen words, MSB first, in order q1w, q1x, q1y, q1z, g1x, g1y, g1z, q2w, q2x, q2y, q2z, g2x, g2y, g2z.
  - 30: checksum, only when the checksum macro is defined.
- **Capture**: on `data_ready`, the back buffer loads flags and words, `pending` is set, and the 6-bit sequence counter increments (wraps 63→0). The flags byte carries the pre-increment value.
- **Drop**: if `data_ready` arrives while `pending` is already set and no swap happens that cycle, the back buffer is overwritten and `dropped_count` increments, saturating at 255.
- **States**:
  - IDLE: if `pending`, copy back→front, clear `pending`, set byte index to 0, go to SEND.
  - SEND: `tx_data_ready`=1 and `tx_data`=front[index]. On `tx_ack`, the index increments. An ack on the last byte returns the block to IDLE.
- **Simultaneous swap and capture**: the swap takes the old back contents; the new sample lands in the back buffer and `pending` stays 1. This is not a drop.
- `tx_ack` while `tx_data_ready`=0 is ignored.
- Capture during SEND writes only the back buffer; the front buffer is frozen until the next swap.

## Timing
- Reset values: `tx_data_ready`=0, `tx_data`=8'h00, `busy`=0, `dropped_count`=0, state IDLE, `pending`=0, sequence=0, index=0.
- Reset asserted mid-frame aborts the frame immediately. The SPI slave sees `tx_data_ready` fall asynchronously.
- Latency: `data_ready` in cycle N gives `tx_data_ready`=1 with the header byte in cycle N+2.
- `tx_ack` in cycle M: `tx_data` shows the next byte in M+1, and `tx_data_ready` stays high.
- `tx_ack` on the last byte in cycle M: `tx_data_ready`=0 in M+1.
  - If `pending`, the next header appears in M+2.
  - There is therefore a minimum one-cycle gap between frames.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SENSOR_FRAME_CHECKSUM_EN` defined:
  - The frame is 31 bytes.
  - Byte 30 = 8-bit modulo-256 sum of bytes 1..29 (header excluded), computed at swap time and stored in the front buffer.
- Not defined: the frame is 30 bytes, and the ack on byte 29 ends it.

## Structure
- Package `sensor_frame_pkg`:
  - `FRAME_LEN` (30 or 31, selected by the macro), `IDX_W`.
  - State enum `frame_state_t` {IDLE, SEND}.
  - Flag bit positions.
- Sub-module `frame_byte_select`: purely combinational; front buffer plus index → byte. The top level registers its output into `tx_data`.

## Test plan
- **Single sample, macro on**: one `data_ready` with q1w=16'h1234, all other words 0, both valids=1.
  - Header 0xAA appears 2 cycles later.
  - Acking every byte yields 0xAA, 0x03, 0x12, 0x34, 26×0x00, checksum 0x49.
  - `tx_data_ready` drops after the 31st ack.
- **Mid-frame capture**: a second `data_ready` (q1w=16'h5678) at ack 10 of frame 1.
  - Frame 1 bytes are unchanged.
  - Frame 2 header appears 2 cycles after the last ack, flags=0x07 (sequence=1).
- **Overrun**: three `data_ready` pulses during one frame.
  - `dropped_count`=2; the next frame carries the third sample.
  - 300 overruns saturate `dropped_count` at 255.
- **Simultaneous swap and capture**: `data_ready` in the same cycle IDLE swaps a pending frame.
  - `dropped_count` is unchanged and `pending`=1 afterwards.
  - Two consecutive frames are emitted.
- **Reset mid-frame**: `rst` pulse at byte 15.
  - `tx_data_ready`=0 and `dropped_count`=0.
  - The next sample's flags show sequence 0.
- **Macro off**: the frame ends after 30 acks with no checksum byte; a stray `tx_ack` while idle is ignored.

Source files
------------

// File: rtl/sensor_frame_pkg.sv
// sensor_frame_pkg: shared frame geometry, FSM states and frame builder for sensor_frame_buffer
// Optional checksum byte enabled by defining SENSOR_FRAME_CHECKSUM_EN.
package sensor_frame_pkg;
`ifdef SENSOR_FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = 31;
`else
    localparam int FRAME_LEN = 30;
`endif
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int N_WORDS = 14;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam int FLAG_S1 = 0;
    localparam int FLAG_S2 = 1;
    localparam int FLAG_SEQ_LSB = 2;

    typedef enum logic {IDLE, SEND} frame_state_t;
    typedef logic [FRAME_LEN-1:0][7:0] frame_t;
    typedef struct packed {
        logic [7:0]                flags;
        logic [N_WORDS-1:0][15:0]  words;
    } sample_t;

    // Lays out header, flags and MSB-first words; checksum covers bytes 1..29.
    function automatic frame_t build_frame(input logic [7:0] header, input sample_t s);
        frame_t f;
        f = '0;
        f[0] = header;
        f[1] = s.flags;
        for (int i = 0; i < N_WORDS; i++) begin
            f[2 + 2 * i] = s.words[i][15:8];
            f[3 + 2 * i] = s.words[i][7:0];
        end
`ifdef SENSOR_FRAME_CHECKSUM_EN
        for (int i = 1; i < 30; i++) f[30] = f[30] + f[i];
`endif
        return f;
    endfunction
endpackage

// File: rtl/sensor_frame_buffer_byte_select.sv
// frame_byte_select: combinational front-buffer byte mux (frame_i + idx_i -> byte_o)
import sensor_frame_pkg::*;
module frame_byte_select (
    input  frame_t           frame_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [7:0]       byte_o
);
    assign byte_o = (idx_i <= LAST_IDX) ? frame_i[idx_i] : 8'h00;
endmodule

// File: rtl/sensor_frame_buffer.sv
// sensor_frame_buffer: double-buffered two-sensor sample capture, serialised as a byte frame over ready/ack
// Ports: clk, rst (async active-high); data_ready + sensor valids + 14 sample words in;
// tx_ack in; tx_data_ready, tx_data, busy, dropped_count out (all registered).
// Define SENSOR_FRAME_CHECKSUM_EN for a 31-byte frame with trailing checksum.
import sensor_frame_pkg::*;
module sensor_frame_buffer #(
    parameter logic [7:0] HEADER_BYTE = 8'hAA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_ready,
    input  logic               sensor1_valid,
    input  logic               sensor2_valid,
    input  logic signed [15:0] quat1_w,
    input  logic signed [15:0] quat1_x,
    input  logic signed [15:0] quat1_y,
    input  logic signed [15:0] quat1_z,
    input  logic signed [15:0] gyro1_x,
    input  logic signed [15:0] gyro1_y,
    input  logic signed [15:0] gyro1_z,
    input  logic signed [15:0] quat2_w,
    input  logic signed [15:0] quat2_x,
    input  logic signed [15:0] quat2_y,
    input  logic signed [15:0] quat2_z,
    input  logic signed [15:0] gyro2_x,
    input  logic signed [15:0] gyro2_y,
    input  logic signed [15:0] gyro2_z,
    output logic               tx_data_ready,
    output logic [7:0]         tx_data,
    input  logic               tx_ack,
    output logic               busy,
    output logic [7:0]         dropped_count
);
    frame_state_t     state_q, state_d;
    logic             pending_q, pending_d;
    logic [5:0]       seq_q, seq_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
    sample_t          back_q, back_d, sample_in;
    frame_t           front_q, front_d;
    logic             rdy_q, rdy_d, busy_q, busy_d;
    logic [7:0]       data_q, data_d, drop_q, drop_d, next_byte;
    logic             swap, ack;

    assign idx_nxt = idx_q + 1'b1;

    frame_byte_select u_sel (
        .frame_i (front_q),
        .idx_i   (idx_nxt),
        .byte_o  (next_byte)
    );

    always_comb begin
        sample_in.flags = {seq_q, sensor2_valid, sensor1_valid};
        sample_in.words = {gyro2_z, gyro2_y, gyro2_x, quat2_z, quat2_y, quat2_x, quat2_w,
                           gyro1_z, gyro1_y, gyro1_x, quat1_z, quat1_y, quat1_x, quat1_w};
        swap      = (state_q == IDLE) && pending_q;
        ack       = (state_q == SEND) && rdy_q && tx_ack;
        back_d    = data_ready ? sample_in : back_q;
        seq_d     = seq_q + 6'(data_ready);
        // a capture in the swap cycle refills the back buffer, so pending survives
        pending_d = data_ready | (pending_q & ~swap);
        drop_d    = (data_ready && pending_q && !swap && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        state_d   = state_q;
        idx_d     = idx_q;
        front_d   = front_q;
        rdy_d     = rdy_q;
        data_d    = data_q;
        if (swap) begin
            front_d = build_frame(HEADER_BYTE, back_q);
            idx_d   = '0;
            state_d = SEND;
            rdy_d   = 1'b1;
            data_d  = HEADER_BYTE;
        end else if (ack) begin
            idx_d   = idx_nxt;
            data_d  = next_byte;
            state_d = (idx_q == LAST_IDX) ? IDLE : SEND;
            rdy_d   = (idx_q != LAST_IDX);
        end
        busy_d = (state_d == SEND) || pending_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            seq_q     <= '0;
            idx_q     <= '0;
            back_q    <= '0;
            front_q   <= '0;
            rdy_q     <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            seq_q     <= seq_d;
            idx_q     <= idx_d;
            back_q    <= back_d;
            front_q   <= front_d;
            rdy_q     <= rdy_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    assign tx_data_ready = rdy_q;
    assign tx_data       = data_q;
    assign busy          = busy_q;
    assign dropped_count = drop_q;
endmodule

// File: tb/tb_sensor_frame_buffer.sv
// tb_sensor_frame_buffer: scoreboard bench for sensor_frame_buffer
module tb_sensor_frame_buffer;
`ifdef SENSOR_FRAME_CHECKSUM_EN
    localparam int FL = 31;
`else
    localparam int FL = 30;
`endif
    logic clk = 0, rst = 1, data_ready = 0, s1v = 0, s2v = 0, tx_ack = 0;
    logic [15:0] w [14];
    logic tx_data_ready, busy;
    logic [7:0] tx_data, dropped_count;
    int n_chk = 0, n_fail = 0;
    logic [7:0] exp_q [$];
    logic [5:0] seq_m = 0;

    always #5 clk = ~clk;

    sensor_frame_buffer #(.HEADER_BYTE(8'hAA)) dut (
        .clk(clk), .rst(rst), .data_ready(data_ready),
        .sensor1_valid(s1v), .sensor2_valid(s2v),
        .quat1_w(w[0]), .quat1_x(w[1]), .quat1_y(w[2]), .quat1_z(w[3]),
        .gyro1_x(w[4]), .gyro1_y(w[5]), .gyro1_z(w[6]),
        .quat2_w(w[7]), .quat2_x(w[8]), .quat2_y(w[9]), .quat2_z(w[10]),
        .gyro2_x(w[11]), .gyro2_y(w[12]), .gyro2_z(w[13]),
        .tx_data_ready(tx_data_ready), .tx_data(tx_data), .tx_ack(tx_ack),
        .busy(busy), .dropped_count(dropped_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_data_ready && tx_ack) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL frame byte: got %02h with no byte expected", tx_data);
            end else begin
                check("frame byte", tx_data, exp_q.pop_front());
            end
        end
    end

    task automatic cap(input logic v1, input logic v2, input logic [15:0] q1w,
                       input logic [15:0] fill, input bit push);
        logic [7:0] sum, b;
        w[0] = q1w;
        for (int i = 1; i < 14; i++) w[i] = (fill == 0) ? 16'h0 : fill + 16'(i);
        s1v = v1;
        s2v = v2;
        if (push) begin
            exp_q.push_back(8'hAA);
            b = {seq_m, v2, v1};
            exp_q.push_back(b);
            sum = b;
            for (int i = 0; i < 14; i++) begin
                exp_q.push_back(w[i][15:8]);
                exp_q.push_back(w[i][7:0]);
                sum = sum + w[i][15:8] + w[i][7:0];
            end
            if (FL == 31) exp_q.push_back(sum);
        end
        data_ready = 1;
        @(posedge clk); #1;
        data_ready = 0;
        seq_m++;
    endtask

    task automatic ack_n(input int n);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            while (!tx_data_ready && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            check("ready wait", tx_data_ready, 1);
            if (!tx_data_ready) return;
            tx_ack = 1;
            @(posedge clk); #1;
            tx_ack = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        seq_m = 0;
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 14; i++) w[i] = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset rdy", tx_data_ready, 0);
        check("reset data", tx_data, 8'h00);
        check("reset busy", busy, 0);
        check("reset drop", dropped_count, 0);
        rst = 0;

        // single sample: flags 0x03, checksum 0x49 when enabled
        cap(1, 1, 16'h1234, 16'h0, 1);
        check("lat n+1 rdy", tx_data_ready, 0);
        @(posedge clk); #1;
        check("lat n+2 rdy", tx_data_ready, 1);
        check("lat n+2 hdr", tx_data, 8'hAA);
        check("busy send", busy, 1);
        ack_n(FL);
        check("end rdy", tx_data_ready, 0);
        check("end busy", busy, 0);

        // mid-frame capture: frame 1 intact, frame 2 flags 0x07 one gap cycle later
        do_reset();
        cap(1, 1, 16'hBEEF, 16'h0100, 1);
        ack_n(10);
        cap(1, 1, 16'h5678, 16'h0, 1);
        ack_n(FL - 10);
        check("gap rdy", tx_data_ready, 0);
        @(posedge clk); #1;
        check("f2 rdy", tx_data_ready, 1);
        check("f2 hdr", tx_data, 8'hAA);
        ack_n(FL);

        // overrun: three captures in one frame, third one is sent
        do_reset();
        cap(1, 0, 16'h1111, 16'h2000, 1);
        ack_n(5);
        cap(0, 1, 16'h2222, 16'h3000, 0);
        cap(1, 1, 16'h3333, 16'h4000, 0);
        cap(1, 0, 16'h4444, 16'h5000, 1);
        check("drop 2", dropped_count, 2);
        ack_n(FL - 5);
        ack_n(FL);
        check("overrun end rdy", tx_data_ready, 0);

        // saturation, then async reset at byte 15 of the frozen frame
        cap(1, 1, 16'h7777, 16'h6000, 1);
        for (int i = 0; i < 300; i++) cap(0, 0, 16'h0, 16'h0, 0);
        check("drop sat", dropped_count, 255);
        ack_n(15);
        #2 rst = 1;
        #1;
        check("async rdy", tx_data_ready, 0);
        check("async drop", dropped_count, 0);
        check("async busy", busy, 0);
        @(posedge clk); #1;
        rst = 0;
        seq_m = 0;
        exp_q.delete();
        cap(1, 0, 16'hABCD, 16'h1000, 1);
        ack_n(FL);

        // simultaneous swap and capture
        do_reset();
        cap(1, 1, 16'hA001, 16'h0A00, 1);
        ack_n(3);
        cap(0, 1, 16'hB002, 16'h0B00, 1);
        ack_n(FL - 3);
        cap(1, 0, 16'hC003, 16'h0C00, 1);
        check("sim drop", dropped_count, 0);
        check("sim busy", busy, 1);
        check("sim rdy", tx_data_ready, 1);
        check("sim hdr", tx_data, 8'hAA);
        ack_n(FL);
        check("sim gap rdy", tx_data_ready, 0);
        check("sim gap busy", busy, 1);
        @(posedge clk); #1;
        check("sim f3 rdy", tx_data_ready, 1);
        ack_n(FL);
        check("sim end busy", busy, 0);

        // stray ack while idle is ignored
        tx_ack = 1;
        @(posedge clk); #1;
        tx_ack = 0;
        check("stray rdy", tx_data_ready, 0);
        cap(1, 1, 16'h0001, 16'h0, 1);
        ack_n(FL);
        check("stray end rdy", tx_data_ready, 0);
        check("queue empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
